// File: rtl/tt_um_wave_source.sv
// rtl/tt_um_wave_source.sv - prescaled ramp/triangle/square/noise sample source
// Optional LFSR noise on SEL=3 when WAVE_SOURCE_NOISE_EN is defined, else constant 0x80.
module tt_um_wave_source (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state;
  logic [3:0] pc;
  logic [7:0] phase;
  logic [7:0] sample;
  logic       strobe;
  logic       wrap;
  logic [5:0] count;
  logic       run_en;
  logic       tick;
  logic       entry;
  logic [7:0] wave;
  logic       unused_bits;

  assign run_en = ui_in[7] & ena;
  assign entry  = (state == IDLE) && run_en;
  // A cycle leaving RUN never ticks; the same edge performs the exit clearing.
  assign tick   = (state == RUN) && run_en && (pc >= ui_in[5:2]);

`ifdef WAVE_SOURCE_NOISE_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr <= 8'hA5;
    else if (entry)
      lfsr <= 8'hA5;
    else if (tick)
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
`endif

  always_comb begin
    wave = phase;
    case (ui_in[1:0])
      2'd0: wave = phase;
      2'd1: wave = phase[7] ? ~{phase[6:0], 1'b0} : {phase[6:0], 1'b0};
      2'd2: wave = phase[7] ? 8'hFF : 8'h00;
`ifdef WAVE_SOURCE_NOISE_EN
      default: wave = lfsr;
`else
      default: wave = 8'h80;
`endif
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= 4'd0;
      phase  <= 8'd0;
      sample <= 8'd0;
      strobe <= 1'b0;
      wrap   <= 1'b0;
      count  <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          pc     <= 4'd0;
          phase  <= 8'd0;
          strobe <= 1'b0;
          wrap   <= 1'b0;
          if (run_en)
            state <= RUN;
        end
        RUN: begin
          if (!run_en) begin
            state  <= IDLE;
            pc     <= 4'd0;
            phase  <= 8'd0;
            strobe <= 1'b0;
            wrap   <= 1'b0;
          end else if (tick) begin
            pc     <= 4'd0;
            sample <= wave;
            phase  <= phase + 8'd1;
            strobe <= 1'b1;
            wrap   <= (phase == 8'hFF);
            count  <= count + 6'd1;
          end else begin
            pc     <= pc + 4'd1;
            strobe <= 1'b0;
            wrap   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign uo_out      = {count, wrap, strobe};
  assign uio_out     = sample;
  assign uio_oe      = 8'hFF;
  assign unused_bits = ^{uio_in, ui_in[6]};

endmodule
